// File: rtl/saida_serial_arbitro_pkg.sv
// Shared definitions for the serial output arbiter: FSM state codes,
// watchdog defaults and an index-width helper.
package saida_serial_arbitro_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        SELECIONA = 3'd1,
        DISPARA   = 3'd2,
        AGUARDA   = 3'd3,
        FINALIZA  = 3'd4,
        ERRO      = 3'd5
    } estado_t;

    localparam int TIMEOUT_PADRAO = 1000000;
    localparam int TMO_W_PADRAO   = 20;

    // A single source still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbitro_rr_prioridade.sv
// Rotating-priority encoder: first pending bit at or after ptr, wrapping modulo N.
module arbitro_rr_prioridade
    import saida_serial_arbitro_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     pendentes,
    input  logic [IDX_W-1:0] ptr,
    output logic             valido,
    output logic [IDX_W-1:0] vencedor
);

    int j;

    // Walk from the farthest candidate back to ptr so the nearest one wins last.
    always_comb begin
        valido   = 1'b0;
        vencedor = '0;
        j        = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (pendentes[IDX_W'(j)]) begin
                valido   = 1'b1;
                vencedor = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/saida_serial_arbitro.sv
// Round-robin arbiter sharing one serial BCD output among N sources, with a
// watchdog that releases the output if the done pulse never arrives.
module saida_serial_arbitro
    import saida_serial_arbitro_pkg::*;
#(
    parameter int N       = 4,
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = TIMEOUT_PADRAO,
    parameter int TMO_W   = TMO_W_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N*DATA_W-1:0] dado_req,
    input  logic                pronto_serial,
    output logic                inicio_serial,
    output logic [DATA_W-1:0]   dado_serial,
    output logic [N-1:0]        concedido,
    output logic [N-1:0]        atendido,
    output logic                ocupado,
    output logic                erro_timeout,
    output logic [2:0]          db_estado
);

    localparam int               IDX_W   = idx_width(N);
    localparam logic [TMO_W-1:0] CNT_MAX = TMO_W'(TIMEOUT - 1);

    estado_t          estado;
    estado_t          proximo;
    logic [N-1:0]     pendentes;
    logic [N-1:0]     limpa;
    logic [N-1:0]     idx_onehot;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_seguinte;
    logic [IDX_W-1:0] vencedor;
    logic             valido;
    logic [TMO_W-1:0] contador;
    logic             estouro;

    arbitro_rr_prioridade #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prioridade (
        .pendentes (pendentes),
        .ptr       (ptr),
        .valido    (valido),
        .vencedor  (vencedor)
    );

    always_comb begin
        idx_onehot      = '0;
        idx_onehot[idx] = 1'b1;
    end

    assign idx_seguinte = (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);
    assign estouro      = (contador == CNT_MAX);
    assign limpa        = (estado == FINALIZA || estado == ERRO) ? idx_onehot : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = OCIOSO;
        case (estado)
            OCIOSO:    proximo = valido ? SELECIONA : OCIOSO;
            SELECIONA: proximo = DISPARA;
            DISPARA:   proximo = AGUARDA;
            AGUARDA: begin
                if (pronto_serial) begin
                    proximo = FINALIZA;
                end else if (estouro) begin
                    proximo = ERRO;
                end else begin
                    proximo = AGUARDA;
                end
            end
            FINALIZA:  proximo = OCIOSO;
            ERRO:      proximo = OCIOSO;
            default:   proximo = OCIOSO;
        endcase
    end

    // A request arriving in the same cycle as its clear stays pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pendentes   <= '0;
            ptr         <= '0;
            idx         <= '0;
            contador    <= '0;
            dado_serial <= '0;
        end else begin
            pendentes <= (pendentes & ~limpa) | req;
            if (estado == SELECIONA) begin
                idx         <= vencedor;
                dado_serial <= dado_req[int'(vencedor) * DATA_W +: DATA_W];
            end
            if (estado == DISPARA) begin
                contador <= '0;
            end else if (estado == AGUARDA && !pronto_serial && !estouro) begin
                contador <= contador + TMO_W'(1);
            end
            if (estado == FINALIZA || estado == ERRO) begin
                ptr <= idx_seguinte;
            end
        end
    end

    always_comb begin
        inicio_serial = (estado == DISPARA);
        erro_timeout  = (estado == ERRO);
        ocupado       = (estado != OCIOSO);
        atendido      = (estado == FINALIZA) ? idx_onehot : '0;
        concedido     = (estado == DISPARA || estado == AGUARDA ||
                         estado == FINALIZA || estado == ERRO) ? idx_onehot : '0;
        db_estado     = estado;
    end

endmodule

// File: tb/tb_saida_serial_arbitro.sv
// Scoreboard bench for saida_serial_arbitro: expected grants are queued when
// requests are driven and retired when the DUT starts, acknowledges or aborts.
module tb_saida_serial_arbitro;

    localparam int N       = 4;
    localparam int DATA_W  = 12;
    localparam int TIMEOUT = 24;
    localparam int TMO_W   = 5;

    logic                clock;
    logic                reset;
    logic [N-1:0]        req;
    logic [N*DATA_W-1:0] dado_req;
    logic                pronto_serial;
    logic                inicio_serial;
    logic [DATA_W-1:0]   dado_serial;
    logic [N-1:0]        concedido;
    logic [N-1:0]        atendido;
    logic                ocupado;
    logic                erro_timeout;
    logic [2:0]          db_estado;

    typedef struct {
        int          src;
        logic [11:0] data;
        int          delay;
        bit          tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   active;
    int   since;
    int   compared;
    int   mismatched;

    saida_serial_arbitro #(
        .N       (N),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .dado_req      (dado_req),
        .pronto_serial (pronto_serial),
        .inicio_serial (inicio_serial),
        .dado_serial   (dado_serial),
        .concedido     (concedido),
        .atendido      (atendido),
        .ocupado       (ocupado),
        .erro_timeout  (erro_timeout),
        .db_estado     (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] oh(input int s);
        return 32'(1) << s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observado, input logic [31:0] esperado);
        compared++;
        if (observado !== esperado) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observado, esperado);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_inicio"},    32'(inicio_serial), 0);
        checkOutput({tag, "_dado"},      32'(dado_serial),   0);
        checkOutput({tag, "_concedido"}, 32'(concedido),     0);
        checkOutput({tag, "_atendido"},  32'(atendido),      0);
        checkOutput({tag, "_ocupado"},   32'(ocupado),       0);
        checkOutput({tag, "_erro"},      32'(erro_timeout),  0);
        checkOutput({tag, "_estado"},    32'(db_estado),     0);
    endtask

    task automatic pushExp(input int s, input logic [11:0] d, input int dl, input bit t);
        exp_t e;
        e.src   = s;
        e.data  = d;
        e.delay = dl;
        e.tmo   = t;
        exp_q.push_back(e);
    endtask

    task automatic setDado(input int s, input logic [11:0] d);
        dado_req[s * DATA_W +: DATA_W] = d;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r);
        req = r;
        @(negedge clock);
        req = '0;
    endtask

    task automatic waitStart(input string tag);
        int n;
        n = 0;
        while (!inicio_serial && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput({"inicio_", tag}, 32'(inicio_serial), 1);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || active || ocupado) && n < 600) begin
            @(negedge clock);
            n++;
        end
        checkOutput({"fila_vazia_", tag}, 32'(exp_q.size()), 0);
        checkOutput({"ocioso_", tag},     32'(ocupado),      0);
        repeat (2) @(negedge clock);
    endtask

    // Monitor retires scoreboard entries and plays the serial subsystem's done pulse.
    initial begin
        pronto_serial = 1'b0;
        active        = 1'b0;
        since         = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                active        = 1'b0;
                pronto_serial = 1'b0;
            end else begin
                if (active) since++;
                if (pronto_serial) begin
                    pronto_serial = 1'b0;
                    checkOutput("atendido",        32'(atendido),    oh(cur.src));
                    checkOutput("estado_finaliza", 32'(db_estado),   4);
                    checkOutput("dado_estavel",    32'(dado_serial), 32'(cur.data));
                    active = 1'b0;
                end else if (atendido != '0) begin
                    checkOutput("atendido_inesperado", 32'(atendido), 0);
                end
                if (erro_timeout) begin
                    checkOutput("erro_esperado",    32'(active && cur.tmo), 1);
                    checkOutput("ciclos_timeout",   32'(since),     TIMEOUT + 1);
                    checkOutput("atendido_no_erro", 32'(atendido),  0);
                    checkOutput("estado_erro",      32'(db_estado), 5);
                    active = 1'b0;
                end
                if (inicio_serial) begin
                    if (active) begin
                        checkOutput("inicio_durante_servico", 32'(inicio_serial && active), 0);
                    end
                    if (exp_q.size() == 0) begin
                        checkOutput("inicio_inesperado", 32'(inicio_serial), 0);
                    end else begin
                        cur = exp_q.pop_front();
                        checkOutput("concedido",      32'(concedido),   oh(cur.src));
                        checkOutput("dado_serial",    32'(dado_serial), 32'(cur.data));
                        checkOutput("estado_dispara", 32'(db_estado),   2);
                        active = 1'b1;
                        since  = 0;
                    end
                end else if (active && !cur.tmo && since == cur.delay) begin
                    pronto_serial = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int starts;
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        req        = '0;
        dado_req   = '0;
        repeat (3) @(negedge clock);
        checkResetOutputs("reset_inicial");
        reset = 1'b0;
        for (int s = 0; s < N; s++) setDado(s, 12'(12'h101 * (s + 1)));
        @(negedge clock);

        $display("[TB] contention: all four sources at once");
        for (int s = 0; s < N; s++) pushExp(s, 12'(12'h101 * (s + 1)), 3 + s, 1'b0);
        applyStimulus(4'b1111);
        waitIdle("contencao");

        $display("[TB] single request on source 1");
        setDado(1, 12'h257);
        pushExp(1, 12'h257, 20, 1'b0);
        req = 4'b0010;
        @(negedge clock);
        req = '0;
        lat = 1;
        while (!inicio_serial && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        checkOutput("latencia_inicio", 32'(lat), 3);
        setDado(1, 12'hAAA);
        waitIdle("unico");

        $display("[TB] fairness with pointer at 3");
        pushExp(2, 12'h303, 5, 1'b0);
        applyStimulus(4'b0100);
        waitIdle("serve_2");
        pushExp(0, 12'h101, 4, 1'b0);
        pushExp(2, 12'h303, 4, 1'b0);
        applyStimulus(4'b0101);
        waitIdle("justica_ptr3");

        $display("[TB] fairness with pointer at 1");
        pushExp(0, 12'h101, 2, 1'b0);
        applyStimulus(4'b0001);
        waitIdle("serve_0");
        pushExp(2, 12'h303, 3, 1'b0);
        pushExp(0, 12'h101, 3, 1'b0);
        applyStimulus(4'b0101);
        waitIdle("justica_ptr1");

        $display("[TB] timeout on source 3, then source 0");
        pushExp(3, 12'h404, 0, 1'b1);
        pushExp(0, 12'h101, 6, 1'b0);
        applyStimulus(4'b1001);
        waitIdle("timeout");

        $display("[TB] re-request of source 1 during its own service");
        setDado(1, 12'h369);
        pushExp(1, 12'h369, 10, 1'b0);
        pushExp(1, 12'h147, 4, 1'b0);
        applyStimulus(4'b0010);
        waitStart("rerequest");
        setDado(1, 12'h147);
        repeat (3) @(negedge clock);
        req = 4'b0010;
        @(negedge clock);
        req = '0;
        repeat (6) @(negedge clock);
        @(negedge clock);
        checkOutput("finaliza_alinhado", 32'(atendido), 32'(4'b0010));
        req = 4'b0010;
        @(negedge clock);
        req = '0;
        waitIdle("rerequest");

        $display("[TB] asynchronous reset while waiting");
        pushExp(3, 12'h404, 0, 1'b1);
        applyStimulus(4'b1010);
        waitStart("pre_reset");
        repeat (3) @(negedge clock);
        checkOutput("aguarda_pre_reset", 32'(db_estado), 3);
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs("reset_assincrono");
        exp_q.delete();
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b0;
        starts = 0;
        repeat (15) begin
            @(negedge clock);
            if (inicio_serial) starts++;
        end
        checkOutput("sem_inicio_pos_reset", 32'(starts),  0);
        checkOutput("ocupado_pos_reset",    32'(ocupado), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
